// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the CPU-to-test-RAM memory controller: op codes,
// controller state encoding and default RAM depth.
package mem_ctrl_pkg;

    localparam int unsigned MEM_DEPTH_DEF = 64;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ISZ = 2'b10;
    localparam logic [1:0] OP_DSZ = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDCAP,
        ST_RMW_WR,
        ST_ERR
    } state_e;

endpackage

// File: rtl/mem_bus_ctrl_rmw_alu.sv
// Combinational increment/decrement unit for ISZ/DSZ, wrapping modulo 2^16.
module rmw_alu (
    input  logic [15:0] operand,
    input  logic        dec,
    output logic [15:0] result,
    output logic        zero
);

    always_comb begin
        result = dec ? (operand - 16'd1) : (operand + 16'd1);
        zero   = (result == '0);
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequencing controller between CPU request handshake and single-port test RAM.
// Define MEM_BUS_CTRL_RMW_EN to enable ISZ/DSZ read-modify-write; otherwise ops 10/11 act as reads.
module mem_bus_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int unsigned ADDR_W    = 15
) (
    input  logic              test_clk,
    input  logic              test_rst_n,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_skip,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] mem_test_addr,
    output logic              mem_test_we,
    output logic [15:0]       mem_test_wdata,
    input  logic [15:0]       mem_test_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              skip_q, skip_d;
    logic              err_q, err_d;
    logic              in_range;

    assign in_range = (32'(cpu_addr) < MEM_DEPTH);

`ifdef MEM_BUS_CTRL_RMW_EN
    logic [1:0]  op_q, op_d;
    logic        zero_q, zero_d;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        is_rmw;

    assign is_rmw = (op_q == OP_ISZ) || (op_q == OP_DSZ);

    rmw_alu u_rmw_alu (
        .operand (mem_test_rdata),
        .dec     (op_q == OP_DSZ),
        .result  (alu_result),
        .zero    (alu_zero)
    );
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        skip_d  = 1'b0;
        err_d   = 1'b0;
`ifdef MEM_BUS_CTRL_RMW_EN
        op_d    = op_q;
        zero_d  = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d = cpu_addr;
`ifdef MEM_BUS_CTRL_RMW_EN
                    op_d   = cpu_op;
`endif
                    if (!in_range) begin
                        state_d = ST_ERR;
                    end else if (cpu_op == OP_WR) begin
                        we_d    = 1'b1;
                        wdata_d = cpu_wdata;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_WR: begin
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RD: state_d = ST_RDCAP;
            ST_RDCAP: begin
`ifdef MEM_BUS_CTRL_RMW_EN
                if (is_rmw) begin
                    // Address is still held from accept, so write-back hits the same word.
                    wdata_d = alu_result;
                    zero_d  = alu_zero;
                    we_d    = 1'b1;
                    state_d = ST_RMW_WR;
                end else begin
                    rdata_d = mem_test_rdata;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`else
                rdata_d = mem_test_rdata;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
`endif
            end
`ifdef MEM_BUS_CTRL_RMW_EN
            ST_RMW_WR: begin
                rdata_d = wdata_q;
                skip_d  = zero_q;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            ST_ERR: begin
                rdata_d = '0;
                err_d   = 1'b1;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge test_clk or negedge test_rst_n) begin
        if (!test_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            skip_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_BUS_CTRL_RMW_EN
            op_q    <= OP_RD;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
`ifdef MEM_BUS_CTRL_RMW_EN
            op_q    <= op_d;
            zero_q  <= zero_d;
`endif
        end
    end

    assign cpu_ready      = (state_q == ST_IDLE);
    assign cpu_ack        = ack_q;
    assign cpu_rdata      = rdata_q;
    assign cpu_skip       = skip_q;
    assign cpu_err        = err_q;
    assign mem_test_addr  = addr_q;
    assign mem_test_we    = we_q;
    assign mem_test_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl with a 64-word registered-read RAM model.
// Expectations follow MEM_BUS_CTRL_RMW_EN when it is defined for the build.
module tb_mem_bus_ctrl;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ISZ = 2'b10;
    localparam logic [1:0] OP_DSZ = 2'b11;

`ifdef MEM_BUS_CTRL_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [1:0]  cpu_op = 2'b00;
    logic [14:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ready, cpu_ack, cpu_skip, cpu_err;
    logic [15:0] cpu_rdata;
    logic [14:0] mem_test_addr;
    logic        mem_test_we;
    logic [15:0] mem_test_wdata;
    logic [15:0] mem_test_rdata = '0;

    logic [15:0] ram [64];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.MEM_DEPTH(64), .ADDR_W(15)) dut (
        .test_clk       (clk),
        .test_rst_n     (rst_n),
        .cpu_req        (cpu_req),
        .cpu_op         (cpu_op),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ready      (cpu_ready),
        .cpu_ack        (cpu_ack),
        .cpu_rdata      (cpu_rdata),
        .cpu_skip       (cpu_skip),
        .cpu_err        (cpu_err),
        .mem_test_addr  (mem_test_addr),
        .mem_test_we    (mem_test_we),
        .mem_test_wdata (mem_test_wdata),
        .mem_test_rdata (mem_test_rdata)
    );

    // RAM: write when we, otherwise register the addressed word.
    always @(posedge clk) begin
        if (mem_test_we) ram[mem_test_addr[5:0]] <= mem_test_wdata;
        else             mem_test_rdata <= ram[mem_test_addr[5:0]];
    end

    typedef struct {
        logic [1:0]  op;
        logic [14:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic        chk_rd;
        logic [15:0] rdata;
        logic        skip;
        logic        err;
        int          wes;
        logic        chk_ram;
        logic [15:0] ram;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        chk({tag, "_ack"},   32'(cpu_ack), 32'd0);
        chk({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
        chk({tag, "_skip"},  32'(cpu_skip), 32'd0);
        chk({tag, "_err"},   32'(cpu_err), 32'd0);
        chk({tag, "_maddr"}, 32'(mem_test_addr), 32'd0);
        chk({tag, "_we"},    32'(mem_test_we), 32'd0);
        chk({tag, "_mwd"},   32'(mem_test_wdata), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int wes;
        int lat;
        bit got;
        wes = 0;
        lat = 0;
        got = 1'b0;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_op    = v.op;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        chk({tag, "_ready_pre"}, 32'(cpu_ready), 32'd1);
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        wes += int'(mem_test_we);
        for (int i = 1; i <= 8 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            wes += int'(mem_test_we);
            if (cpu_ack) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
        if (got) begin
            if (v.chk_rd) chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(v.rdata));
            chk({tag, "_skip"},  32'(cpu_skip), 32'(v.skip));
            chk({tag, "_err"},   32'(cpu_err), 32'(v.err));
            chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        end
        chk({tag, "_we_cycles"}, 32'(wes), 32'(v.wes));
        if (v.chk_ram) chk({tag, "_ram"}, 32'(ram[v.addr[5:0]]), 32'(v.ram));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int acks;
        for (int i = 0; i < 64; i++) ram[i] = 16'(i * 3);
        ram[9]  = 16'h0003;
        ram[10] = 16'h0010;
        ram[20] = 16'hFFFF;
        ram[21] = 16'h0000;
        ram[22] = 16'h7FFF;
        ram[23] = 16'h0001;
        ram[63] = 16'hFFFE;

        vecs[0]  = '{OP_RD,  15'd9,      16'h0000, 2, 1'b1, 16'h0003, 1'b0, 1'b0, 0, 1'b1, 16'h0003};
        vecs[1]  = '{OP_WR,  15'd16,     16'hBEEF, 1, 1'b0, 16'h0000, 1'b0, 1'b0, 1, 1'b1, 16'hBEEF};
        vecs[2]  = '{OP_RD,  15'd16,     16'h0000, 2, 1'b1, 16'hBEEF, 1'b0, 1'b0, 0, 1'b1, 16'hBEEF};
        vecs[3]  = '{OP_ISZ, 15'd20,     16'h0000, RMW ? 3 : 2, 1'b1, RMW ? 16'h0000 : 16'hFFFF,
                     RMW, 1'b0, RMW ? 1 : 0, 1'b1, RMW ? 16'h0000 : 16'hFFFF};
        vecs[4]  = '{OP_DSZ, 15'd9,      16'h0000, RMW ? 3 : 2, 1'b1, RMW ? 16'h0002 : 16'h0003,
                     1'b0, 1'b0, RMW ? 1 : 0, 1'b1, RMW ? 16'h0002 : 16'h0003};
        vecs[5]  = '{OP_RD,  15'd64,     16'h0000, 1, 1'b1, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 16'h0000};
        vecs[6]  = '{OP_DSZ, 15'd21,     16'h0000, RMW ? 3 : 2, 1'b1, RMW ? 16'hFFFF : 16'h0000,
                     1'b0, 1'b0, RMW ? 1 : 0, 1'b1, RMW ? 16'hFFFF : 16'h0000};
        vecs[7]  = '{OP_ISZ, 15'd22,     16'h0000, RMW ? 3 : 2, 1'b1, RMW ? 16'h8000 : 16'h7FFF,
                     1'b0, 1'b0, RMW ? 1 : 0, 1'b1, RMW ? 16'h8000 : 16'h7FFF};
        vecs[8]  = '{OP_WR,  15'h7FFF,   16'hAAAA, 1, 1'b1, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 16'hFFFE};
        vecs[9]  = '{OP_ISZ, 15'd63,     16'h0000, RMW ? 3 : 2, 1'b1, RMW ? 16'hFFFF : 16'hFFFE,
                     1'b0, 1'b0, RMW ? 1 : 0, 1'b1, RMW ? 16'hFFFF : 16'hFFFE};
        vecs[10] = '{OP_DSZ, 15'd23,     16'h0000, RMW ? 3 : 2, 1'b1, RMW ? 16'h0000 : 16'h0001,
                     RMW, 1'b0, RMW ? 1 : 0, 1'b1, RMW ? 16'h0000 : 16'h0001};
        vecs[11] = '{OP_RD,  15'd9,      16'h0000, 2, 1'b1, RMW ? 16'h0002 : 16'h0003,
                     1'b0, 1'b0, 0, 1'b1, RMW ? 16'h0002 : 16'h0003};

        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back: write then read with cpu_req held through the write ack.
        @(negedge clk);
        cpu_req = 1'b1; cpu_op = OP_WR; cpu_addr = 15'd30; cpu_wdata = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        cpu_op = OP_RD; cpu_wdata = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_wr_ack", 32'(cpu_ack), 32'd1);
        chk("b2b_wr_ready", 32'(cpu_ready), 32'd1);
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        chk("b2b_rd_busy", 32'(cpu_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_rd_noack", 32'(cpu_ack), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_rd_ack", 32'(cpu_ack), 32'd1);
        chk("b2b_rd_data", 32'(cpu_rdata), 32'h5A5A);

        // Reset mid-operation on an ISZ to addr 10.
        @(negedge clk);
        cpu_req = 1'b1; cpu_op = OP_ISZ; cpu_addr = 15'd10;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(posedge clk);
        if (RMW) @(posedge clk);
        @(negedge clk);
        if (RMW) chk("rst_mid_we_before", 32'(mem_test_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acks += int'(cpu_ack);
        end
        chk("rst_mid_no_ack", 32'(acks), 32'd0);
        chk("rst_mid_ready", 32'(cpu_ready), 32'd1);
        chk("rst_mid_ram10", 32'(ram[10]), 32'h0010);

        v = '{OP_ISZ, 15'd10, 16'h0000, RMW ? 3 : 2, 1'b1, RMW ? 16'h0011 : 16'h0010,
              1'b0, 1'b0, RMW ? 1 : 0, 1'b1, RMW ? 16'h0011 : 16'h0010};
        run_vec(v, "isz10");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
